// File: rtl/pk_input_ctrl.sv
// Avalon-MM slave for the ReCOP packet-ready line: sync, edge capture, timestamp, IRQ.
// Optional debounce filter enabled by defining PK_DEBOUNCE_EN.
module pk_input_ctrl #(
    parameter int EDGE_TYPE       = 0,
    parameter int TS_W            = 32,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic        in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int ET = (EDGE_TYPE >= 3) ? 2 : EDGE_TYPE;

    logic            s1, s2, filt, prev;
    logic            rise, fall, det, wr;
    logic [1:0]      irq_mask, capture, capture_nxt, clr;
    logic [TS_W-1:0] ts_cnt, ts_last;
    logic            unused_cfg;

    assign unused_cfg = ^{writedata[31:2], DEBOUNCE_CYCLES[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

`ifdef PK_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] db_cnt;
    logic          filt_q;

    // filt follows s2 only after it has disagreed for a full window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= '0;
            filt_q <= 1'b0;
        end else if (s2 == filt_q) begin
            db_cnt <= '0;
        end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt <= '0;
            filt_q <= s2;
        end else begin
            db_cnt <= db_cnt + CW'(1);
        end
    end

    assign filt = filt_q;
`else
    assign filt = s2;
`endif

    assign rise = filt & ~prev;
    assign fall = ~filt & prev;

    always_comb begin
        det = rise | fall;
        unique case (ET)
            0:       det = rise;
            1:       det = fall;
            default: det = rise | fall;
        endcase
    end

    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == 2'd2) ? writedata[1:0] : 2'b00;

    // a new edge beats a same-cycle clear; overrun sees pre-clear pending
    always_comb begin
        capture_nxt    = capture & ~clr;
        capture_nxt[0] = det | capture_nxt[0];
        capture_nxt[1] = (det & capture[0]) | capture_nxt[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= 1'b0;
            irq_mask <= 2'b00;
            capture  <= 2'b00;
            ts_cnt   <= '0;
            ts_last  <= '0;
        end else begin
            prev    <= filt;
            capture <= capture_nxt;
            ts_cnt  <= ts_cnt + TS_W'(1);
            if (det)
                ts_last <= ts_cnt;
            if (wr && address == 2'd1)
                irq_mask <= writedata[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            unique case (address)
                2'd0: readdata <= {31'b0, filt};
                2'd1: readdata <= {30'b0, irq_mask};
                2'd2: readdata <= {30'b0, capture};
                2'd3: readdata <= 32'(ts_last);
            endcase
        end
    end

    assign irq = |(capture & irq_mask);

endmodule
